// File: rtl/scp_pkg.sv
// Shared types for the scp light sequencer.
// State encodings, light bit positions and timer width.
package scp_pkg;

    localparam int TIMER_W = 8;

    localparam int LIGHT_GREEN  = 0;
    localparam int LIGHT_YELLOW = 1;
    localparam int LIGHT_RED    = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT    = 3'd1,
        S_COOLDOWN = 3'd2,
        S_LOCKDOWN = 3'd3
    } state_e;

endpackage

// File: rtl/light_dwell_timer.sv
// Saturating per-state dwell counter.
// Compare flags feed the sequencer release logic.
module light_dwell_timer
    import scp_pkg::*;
#(
    parameter int HOLD_MIN = 3,
    parameter int HOLD_MAX = 8,
    parameter int COOLDOWN = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               en,
    output logic [TIMER_W-1:0] timer,
    output logic               at_min,
    output logic               at_max,
    output logic               at_cool
);

    localparam logic [TIMER_W-1:0] MIN_C  = TIMER_W'(HOLD_MIN - 1);
    localparam logic [TIMER_W-1:0] MAX_C  = TIMER_W'(HOLD_MAX - 1);
    localparam logic [TIMER_W-1:0] COOL_C = TIMER_W'(COOLDOWN - 1);

    // Count cycles in the current state, clearing on state change.
    always_ff @(posedge clock) begin
        if (!reset_n || clr) begin
            timer <= '0;
        end else if (en && (timer != '1)) begin
            timer <= timer + 1'b1;
        end
    end

    assign at_min  = (timer >= MIN_C);
    assign at_max  = (timer == MAX_C);
    assign at_cool = (timer == COOL_C);

endmodule

// File: rtl/scp_light_sequencer.sv
// Arbitrates green/yellow/red requesters onto a one-hot light bus.
// Red has priority; green and yellow alternate round-robin.
module scp_light_sequencer
    import scp_pkg::*;
#(
    parameter int HOLD_MIN = 3,
    parameter int HOLD_MAX = 8,
    parameter int COOLDOWN = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_green,
    input  logic               req_yellow,
    input  logic               req_red,
    output logic               green,
    output logic               yellow,
    output logic               red,
    output logic               timeout,
    output logic [2:0]         state,
    output logic [TIMER_W-1:0] timer
);

    localparam logic [2:0] L_GREEN  = 3'(1 << LIGHT_GREEN);
    localparam logic [2:0] L_YELLOW = 3'(1 << LIGHT_YELLOW);
    localparam logic [2:0] L_RED    = 3'(1 << LIGHT_RED);

    state_e     state_q, state_d;
    logic [2:0] lights_q, lights_d;
    logic       ptr_q, ptr_d;
    logic       timeout_q, timeout_d;
    logic       at_min, at_max, at_cool;
    logic       owner_req, voluntary, pick_yellow;

    light_dwell_timer #(
        .HOLD_MIN (HOLD_MIN),
        .HOLD_MAX (HOLD_MAX),
        .COOLDOWN (COOLDOWN)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (state_d != state_q),
        .en      (1'b1),
        .timer   (timer),
        .at_min  (at_min),
        .at_max  (at_max),
        .at_cool (at_cool)
    );

    // Next state, next lights, pointer and timeout pulse.
    always_comb begin
        state_d     = state_q;
        lights_d    = lights_q;
        ptr_d       = ptr_q;
        timeout_d   = 1'b0;
        owner_req   = lights_q[LIGHT_YELLOW] ? req_yellow : req_green;
        voluntary   = at_min && (!owner_req || req_red);
        pick_yellow = req_yellow && (!req_green || ptr_q);
        case (state_q)
            S_IDLE: begin
                lights_d = '0;
                if (req_red) begin
                    state_d  = S_LOCKDOWN;
                    lights_d = L_RED;
                end else if (req_green || req_yellow) begin
                    state_d  = S_GRANT;
                    lights_d = pick_yellow ? L_YELLOW : L_GREEN;
                end
            end
            S_GRANT: begin
                if (voluntary || at_max) begin
                    state_d   = S_COOLDOWN;
                    lights_d  = '0;
                    ptr_d     = !lights_q[LIGHT_YELLOW];
                    timeout_d = at_max && !voluntary;
                end
            end
            S_LOCKDOWN: begin
                if (at_min && !req_red) begin
                    state_d  = S_COOLDOWN;
                    lights_d = '0;
                end
            end
            S_COOLDOWN: begin
                lights_d = '0;
                if (at_cool) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                lights_d = '0;
            end
        endcase
    end

    // Register state, lights, pointer and timeout.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            lights_q  <= '0;
            ptr_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lights_q  <= lights_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign green   = lights_q[LIGHT_GREEN];
    assign yellow  = lights_q[LIGHT_YELLOW];
    assign red     = lights_q[LIGHT_RED];
    assign timeout = timeout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_scp_light_sequencer.sv
// Directed bench for scp_light_sequencer.
// Expected values are hand-computed per cycle.
module tb_scp_light_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req_green, req_yellow, req_red;
    logic       green, yellow, red, timeout;
    logic [2:0] state;
    logic [7:0] timer;

    int n_checks = 0;
    int n_pass   = 0;

    scp_light_sequencer #(
        .HOLD_MIN (3),
        .HOLD_MAX (8),
        .COOLDOWN (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_green  (req_green),
        .req_yellow (req_yellow),
        .req_red    (req_red),
        .green      (green),
        .yellow     (yellow),
        .red        (red),
        .timeout    (timeout),
        .state      (state),
        .timer      (timer)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // gyr = {green, yellow, red}
    task automatic chk(input string tag, input logic [2:0] gyr,
                       input logic to, input logic [2:0] st,
                       input logic [7:0] tm);
        logic [14:0] obs;
        logic [14:0] exp_v;
        obs   = {green, yellow, red, timeout, state, timer};
        exp_v = {gyr, to, st, tm};
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed g%b y%b r%b to%b st%0d tm%0d required g%b y%b r%b to%b st%0d tm%0d",
                    tag, green, yellow, red, timeout, state, timer,
                    gyr[2], gyr[1], gyr[0], to, st, tm);
    endtask

    initial begin
        // reset with every requester high
        reset_n = 1'b0;
        req_green = 1'b1; req_yellow = 1'b1; req_red = 1'b1;
        tick(); chk("rst0", 3'b000, 0, 0, 0);
        tick(); chk("rst1", 3'b000, 0, 0, 0);
        reset_n = 1'b1;
        tick(); chk("rst_red", 3'b001, 0, 3, 0);
        // red dropped after 1 cycle still holds 3
        req_green = 0; req_yellow = 0; req_red = 0;
        tick(); chk("lk_min1", 3'b001, 0, 3, 1);
        tick(); chk("lk_min2", 3'b001, 0, 3, 2);
        tick(); chk("lk_cool0", 3'b000, 0, 2, 0);
        tick(); chk("lk_cool1", 3'b000, 0, 2, 1);
        tick(); chk("lk_idle", 3'b000, 0, 0, 0);

        // single-cycle green pulse
        req_green = 1;
        tick(); chk("pg_g0", 3'b100, 0, 1, 0);
        req_green = 0;
        tick(); chk("pg_g1", 3'b100, 0, 1, 1);
        tick(); chk("pg_g2", 3'b100, 0, 1, 2);
        tick(); chk("pg_cool0", 3'b000, 0, 2, 0);
        tick(); chk("pg_cool1", 3'b000, 0, 2, 1);
        tick(); chk("pg_idle", 3'b000, 0, 0, 0);

        // green held: forced release, then green again
        req_green = 1;
        tick(); chk("hg_g0", 3'b100, 0, 1, 0);
        for (int k = 1; k < 8; k++) begin
            tick(); chk("hg_g", 3'b100, 0, 1, 8'(k));
        end
        tick(); chk("hg_to", 3'b000, 1, 2, 0);
        tick(); chk("hg_cool1", 3'b000, 0, 2, 1);
        tick(); chk("hg_idle", 3'b000, 0, 0, 0);
        tick(); chk("hg_again", 3'b100, 0, 1, 0);

        // both held: strict alternation
        req_yellow = 1;
        for (int k = 1; k < 8; k++) begin
            tick(); chk("rr_g", 3'b100, 0, 1, 8'(k));
        end
        tick(); chk("rr_to_g", 3'b000, 1, 2, 0);
        tick(); chk("rr_cool_g", 3'b000, 0, 2, 1);
        tick(); chk("rr_idle_g", 3'b000, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            tick(); chk("rr_y", 3'b010, 0, 1, 8'(k));
        end
        tick(); chk("rr_to_y", 3'b000, 1, 2, 0);
        tick(); chk("rr_cool_y", 3'b000, 0, 2, 1);
        tick(); chk("rr_idle_y", 3'b000, 0, 0, 0);
        tick(); chk("rr_g_back", 3'b100, 0, 1, 0);

        // red raised at green timer 0
        req_yellow = 0; req_red = 1;
        tick(); chk("pr_g1", 3'b100, 0, 1, 1);
        tick(); chk("pr_g2", 3'b100, 0, 1, 2);
        tick(); chk("pr_cool0", 3'b000, 0, 2, 0);
        tick(); chk("pr_cool1", 3'b000, 0, 2, 1);
        tick(); chk("pr_idle", 3'b000, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick(); chk("pr_red", 3'b001, 0, 3, 8'(k));
        end

        // reset during lockdown at timer 5
        reset_n = 0;
        tick(); chk("mid_rst", 3'b000, 0, 0, 0);
        reset_n = 1; req_red = 0;
        req_green = 1; req_yellow = 1;
        tick(); chk("post_rst_ptr", 3'b100, 0, 1, 0);
        req_green = 0;
        tick(); chk("post_rst_g1", 3'b100, 0, 1, 1);
        tick(); chk("post_rst_g2", 3'b100, 0, 1, 2);
        tick(); chk("post_rst_rel", 3'b000, 0, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
